// File: rtl/ram_data_arbiter.sv
// Two-requester arbiter for the shared ram data port: round-robin with a
// capped burst lock for requester 1, registered issue stage, 2-cycle read return.
module ram_data_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_lock,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  wEn,
  output logic [ADDR_WIDTH-1:0] d_address,
  output logic [DATA_WIDTH-1:0] d_write_data,
  input  logic [DATA_WIDTH-1:0] d_read_data
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [0:0] {RR, LOCKED} state_t;

  state_t          state_reg, state_next;
  logic            last_reg, last_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            gnt0, gnt1, accept;

  logic                  issue_valid_reg;
  logic                  issue_owner_reg;
  logic                  issue_we_reg;
  logic [ADDR_WIDTH-1:0] issue_addr_reg;
  logic [DATA_WIDTH-1:0] issue_wdata_reg;

  // Grant selection and arbitration state update
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_next = state_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;

    if (!reset) begin
      case (state_reg)
        RR: begin
          if (m0_req && m1_req) begin
            if (last_reg) gnt0 = 1'b1;
            else          gnt1 = 1'b1;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
        LOCKED: begin
          // Requester 0 gets one slot once the burst cap is hit.
          if (m0_req && (!m1_req || cnt_reg >= CW'(MAX_LOCK))) gnt0 = 1'b1;
          else                                                 gnt1 = m1_req;
        end
        default: ;
      endcase
    end

    accept = gnt0 | gnt1;
    if (accept) last_next = gnt1;

    case (state_reg)
      RR: begin
        if (gnt1 && m1_lock) begin
          state_next = LOCKED;
          cnt_next   = CW'(1);
        end
      end
      LOCKED: begin
        if (!m1_lock || !m1_req) begin
          state_next = RR;
          cnt_next   = '0;
        end else if (gnt0) begin
          cnt_next = '0;
        end else if (gnt1 && cnt_reg < CW'(MAX_LOCK)) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = RR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= RR;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Issue stage: address/data hold when idle, only valid drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      issue_valid_reg <= 1'b0;
      issue_owner_reg <= 1'b0;
      issue_we_reg    <= 1'b0;
      issue_addr_reg  <= '0;
      issue_wdata_reg <= '0;
    end else if (accept) begin
      issue_valid_reg <= 1'b1;
      issue_owner_reg <= gnt1;
      issue_we_reg    <= gnt1 ? m1_we    : m0_we;
      issue_addr_reg  <= gnt1 ? m1_addr  : m0_addr;
      issue_wdata_reg <= gnt1 ? m1_wdata : m0_wdata;
    end else begin
      issue_valid_reg <= 1'b0;
    end
  end

  assign m0_gnt       = gnt0;
  assign m1_gnt       = gnt1;
  assign wEn          = issue_valid_reg & issue_we_reg;
  assign d_address    = issue_addr_reg;
  assign d_write_data = issue_wdata_reg;

  // Per-requester read return registers
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      logic                  rvalid_reg;
      logic [DATA_WIDTH-1:0] rdata_reg;
      logic                  hit;

      assign hit = issue_valid_reg && !issue_we_reg && (issue_owner_reg == 1'(gi));

      always_ff @(posedge clock) begin
        if (reset) begin
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
        end else begin
          rvalid_reg <= hit;
          if (hit) rdata_reg <= d_read_data;
        end
      end
    end
  endgenerate

  assign m0_rvalid = g_ret[0].rvalid_reg;
  assign m0_rdata  = g_ret[0].rdata_reg;
  assign m1_rvalid = g_ret[1].rvalid_reg;
  assign m1_rdata  = g_ret[1].rdata_reg;

endmodule
